// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control bundles for the RV32I pipelined control unit.
// The ALU control enum is also consumed by the Execute-stage ALU.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
  } e_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
  } w_ctrl_t;

  localparam e_ctrl_t E_BUBBLE = '{reg_write: 1'b0, result_src: RES_ALU, mem_write: 1'b0,
                                   jump: 1'b0, branch: 1'b0, alu_ctrl: ALU_ADD, alu_src: 1'b0};
  localparam m_ctrl_t M_BUBBLE = '{reg_write: 1'b0, result_src: RES_ALU, mem_write: 1'b0};
  localparam w_ctrl_t W_BUBBLE = '{reg_write: 1'b0, result_src: RES_ALU};

endpackage

// File: rtl/riscv_pipe_controller_if.sv
// Decode inputs, hazard/ALU feedback and pipelined control outputs of the controller.
// master = datapath/hazard side, slave = the controller itself.
interface riscv_pipe_controller_if;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D;
  logic       ZeroE;
  logic       FlushE;
  logic [1:0] ImmSrcD;
  logic [2:0] ALUControlE;
  logic       ALUSrcE;
  logic       PCSrcE;
  logic       ResultSrcE0;
  logic       RegWriteM;
  logic       MemWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;

  modport master (
    output opD, funct3D, funct7b5D, ZeroE, FlushE,
    input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0,
           RegWriteM, MemWriteM, RegWriteW, ResultSrcW
  );

  modport slave (
    input  opD, funct3D, funct7b5D, ZeroE, FlushE,
    output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0,
           RegWriteM, MemWriteM, RegWriteW, ResultSrcW
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decode: (ALUOp, funct3, op[5], funct7[5]) -> ALU control.
// Unsupported funct3 values under ALUOp 10 raise illegal so the caller can issue a bubble.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output alu_ctrl_e   alu_ctrl,
  output logic        illegal
);

  // ALU operation select from ALUOp and function fields
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            // only R-type (op[5]=1) uses funct7[5] to mean sub; addi ignores it
            if (op5 && funct7b5) begin
              alu_ctrl = ALU_SUB;
            end else begin
              alu_ctrl = ALU_ADD;
            end
          end
          3'b010: alu_ctrl = ALU_SLT;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          default: begin
            alu_ctrl = ALU_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_pipe_controller.sv
// Five-stage RV32I control unit: Decode-stage main decode plus E/M/W control registers.
// PCSrcE and ImmSrcD are combinational; all pipeline state clears asynchronously on reset.
module riscv_pipe_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  riscv_pipe_controller_if.slave   bus
);

  e_ctrl_t     dec_e;
  logic [1:0]  imm_src;
  alu_op_e     alu_op;
  alu_ctrl_e   alu_ctrl;
  logic        alu_illegal;
  e_ctrl_t     e_d, e_q;
  m_ctrl_t     m_d, m_q;
  w_ctrl_t     w_d, w_q;
  logic [1:0]  e_res_src;
  logic [1:0]  w_res_src;

  // Main decode of the Decode-stage opcode
  always_comb begin
    dec_e   = E_BUBBLE;
    imm_src = 2'b00;
    alu_op  = ALUOP_ADD;
    case (bus.opD)
      OP_LW: begin
        dec_e.reg_write  = 1'b1;
        dec_e.alu_src    = 1'b1;
        dec_e.result_src = RES_MEM;
      end
      OP_SW: begin
        imm_src          = 2'b01;
        dec_e.alu_src    = 1'b1;
        dec_e.mem_write  = 1'b1;
      end
      OP_R: begin
        dec_e.reg_write  = 1'b1;
        alu_op           = ALUOP_FUNCT;
      end
      OP_I: begin
        dec_e.reg_write  = 1'b1;
        dec_e.alu_src    = 1'b1;
        alu_op           = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        imm_src          = 2'b10;
        dec_e.branch     = 1'b1;
        alu_op           = ALUOP_SUB;
      end
      OP_JAL: begin
        imm_src          = 2'b11;
        dec_e.reg_write  = 1'b1;
        dec_e.result_src = RES_PC4;
        dec_e.jump       = 1'b1;
      end
      default: dec_e = E_BUBBLE;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct3   (bus.funct3D),
    .op5      (bus.opD[5]),
    .funct7b5 (bus.funct7b5D),
    .alu_ctrl (alu_ctrl),
    .illegal  (alu_illegal)
  );

  // Next E contents: flushes and unsupported funct3 both become a bubble
  always_comb begin
    e_d = E_BUBBLE;
    if (bus.FlushE || alu_illegal) begin
      e_d = E_BUBBLE;
    end else begin
      e_d          = dec_e;
      e_d.alu_ctrl = alu_ctrl;
    end
  end

  // Next M and W contents simply advance the older stage
  always_comb begin
    m_d = '{reg_write: e_q.reg_write, result_src: e_q.result_src, mem_write: e_q.mem_write};
    w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src};
  end

  // E/M/W control pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= E_BUBBLE;
      m_q <= M_BUBBLE;
      w_q <= W_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign e_res_src       = e_q.result_src;
  assign w_res_src       = w_q.result_src;

  assign bus.ImmSrcD     = imm_src;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.PCSrcE      = (e_q.branch & bus.ZeroE) | e_q.jump;
  assign bus.ResultSrcE0 = e_res_src[0];
  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.ResultSrcW  = w_res_src;

endmodule

// File: tb/tb_riscv_pipe_controller.sv
// Scoreboard bench for riscv_pipe_controller: each issued instruction queues its hand-computed
// D/E/M/W expectations; a negedge monitor pops and compares them when they fall due.
module tb_riscv_pipe_controller;

  typedef struct {
    int         due;
    logic [5:0] val;
    string      tag;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic pend_zero;
  exp_t q_d[$];
  exp_t q_e[$];
  exp_t q_m[$];
  exp_t q_w[$];
  exp_t mon_r;

  riscv_pipe_controller_if bus_if ();

  riscv_pipe_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int due, input logic [5:0] v, input string t);
    exp_t r;
    r.due = due;
    r.val = v;
    r.tag = t;
    return r;
  endfunction

  task automatic chk(input exp_t r, input logic [5:0] act);
    n_checks++;
    if (r.due != cyc || act !== r.val) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b expected=%b due=%0d", r.tag, cyc, act, r.val, r.due);
    end
  endtask

  // Monitor: E actual = {ALUControlE, ALUSrcE, PCSrcE, ResultSrcE0}
  always @(negedge clk) begin
    if (q_d.size() > 0 && q_d[0].due <= cyc) begin
      mon_r = q_d.pop_front();
      chk(mon_r, {4'b0000, bus_if.ImmSrcD});
    end
    if (q_e.size() > 0 && q_e[0].due <= cyc) begin
      mon_r = q_e.pop_front();
      chk(mon_r, {bus_if.ALUControlE, bus_if.ALUSrcE, bus_if.PCSrcE, bus_if.ResultSrcE0});
    end
    if (q_m.size() > 0 && q_m[0].due <= cyc) begin
      mon_r = q_m.pop_front();
      chk(mon_r, {4'b0000, bus_if.RegWriteM, bus_if.MemWriteM});
    end
    if (q_w.size() > 0 && q_w[0].due <= cyc) begin
      mon_r = q_w.pop_front();
      chk(mon_r, {3'b000, bus_if.RegWriteW, bus_if.ResultSrcW});
    end
  end

  task automatic check_all_zero(input string t);
    logic [11:0] act;
    act = {bus_if.ALUControlE, bus_if.ALUSrcE, bus_if.PCSrcE, bus_if.ResultSrcE0,
           bus_if.RegWriteM, bus_if.MemWriteM, bus_if.RegWriteW, bus_if.ResultSrcW};
    n_checks++;
    if (act !== 12'h000) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", t, act, 12'h000);
    end
  endtask

  // Drive one instruction in D (ZeroE belongs to the instruction now in E) and queue expectations
  task automatic drive_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic fl, input logic zero_next, input logic [1:0] imm,
                           input logic [5:0] e, input logic [1:0] m, input logic [2:0] w,
                           input string t);
    bus_if.opD       = op;
    bus_if.funct3D   = f3;
    bus_if.funct7b5D = f7;
    bus_if.FlushE    = fl;
    bus_if.ZeroE     = pend_zero;
    pend_zero        = zero_next;
    q_d.push_back(mk(cyc,     {4'b0000, imm}, {t, ".ImmSrcD"}));
    q_e.push_back(mk(cyc + 1, e,              {t, ".E"}));
    q_m.push_back(mk(cyc + 2, {4'b0000, m},   {t, ".M"}));
    q_w.push_back(mk(cyc + 3, {3'b000, w},    {t, ".W"}));
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic fl, input logic zero_next, input logic [1:0] imm,
                       input logic [5:0] e, input logic [1:0] m, input logic [2:0] w,
                       input string t);
    @(posedge clk);
    #1;
    drive_row(op, f3, f7, fl, zero_next, imm, e, m, w, t);
  endtask

  // Reset pulse between edges; in-flight expectations are void, pipeline must read zero
  task automatic reset_pulse_then(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [1:0] imm, input logic [5:0] e,
                                  input logic [1:0] m, input logic [2:0] w, input string t);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset_immediate");
    q_d.delete();
    q_e.delete();
    q_m.delete();
    q_w.delete();
    q_e.push_back(mk(cyc,     6'b000000, "rst.E0"));
    q_m.push_back(mk(cyc,     6'b000000, "rst.M0"));
    q_m.push_back(mk(cyc + 1, 6'b000000, "rst.M1"));
    q_w.push_back(mk(cyc,     6'b000000, "rst.W0"));
    q_w.push_back(mk(cyc + 1, 6'b000000, "rst.W1"));
    q_w.push_back(mk(cyc + 2, 6'b000000, "rst.W2"));
    drive_row(op, f3, f7, 1'b0, 1'b0, imm, e, m, w, t);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    pend_zero        = 1'b0;
    reset            = 1'b1;
    bus_if.opD       = 7'b0000000;
    bus_if.funct3D   = 3'b000;
    bus_if.funct7b5D = 1'b0;
    bus_if.ZeroE     = 1'b0;
    bus_if.FlushE    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;

    //     op          f3      f7    fl    zn    imm    E{aluc,src,pc,rs0} M      W
    issue(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000101, 2'b10, 3'b101, "lw");
    issue(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 6'b001000, 2'b10, 3'b100, "sub");
    issue(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 6'b000100, 2'b10, 3'b100, "addi_f7");
    issue(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 6'b101000, 2'b10, 3'b100, "slt");
    issue(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 2'b00, 6'b011100, 2'b10, 3'b100, "ori");
    issue(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 2'b00, 6'b010000, 2'b10, 3'b100, "and");
    issue(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 2'b10, 6'b001010, 2'b00, 3'b000, "beq_taken");
    issue(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 6'b001000, 2'b00, 3'b000, "beq_not");
    issue(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0, 2'b11, 6'b000000, 2'b00, 3'b000, "jal_flush");
    issue(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 2'b11, 6'b000010, 2'b10, 3'b110, "jal");
    issue(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 2'b10, 6'b000000, 2'b00, 3'b000, "beq_flush");
    issue(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b01, 6'b000100, 2'b01, 3'b000, "sw");
    issue(7'b1111111, 3'b010, 1'b1, 1'b0, 1'b1, 2'b00, 6'b000000, 2'b00, 3'b000, "bad_op");
    issue(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000, 2'b00, 3'b000, "bad_f3");

    issue(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000101, 2'b10, 3'b101, "lw2");
    issue(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 2'b01, 6'b000100, 2'b01, 3'b000, "sw2");
    reset_pulse_then(7'b0110011, 3'b000, 1'b1, 2'b00, 6'b001000, 2'b10, 3'b100, "post_rst_sub");

    repeat (4)
      issue(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 6'b000000, 2'b00, 3'b000, "bubble");

    for (int i = 0; i < 10; i++) begin
      if (q_d.size() + q_e.size() + q_m.size() + q_w.size() != 0) @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (q_d.size() + q_e.size() + q_m.size() + q_w.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0",
               q_d.size() + q_e.size() + q_m.size() + q_w.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
